// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared defaults, counter sizing helper and button vector type
package button_pkg;

    localparam int NUM_BUTTONS_DEF     = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    typedef logic [NUM_BUTTONS_DEF-1:0] btn_vec_t;

    // Width of the stability counter; a one-cycle filter still needs one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - two-flop synchroniser plus stability counter for one button
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic key_i,
    output logic button_o,
    output logic stable_o
);

    localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             button_q, button_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            button_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            button_q <= button_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any sample agreeing with the output discards the pending change and restarts the count.
    always_comb begin
        sync1_d  = key_i;
        sync2_d  = sync1_q;
        button_d = button_q;
        cnt_d    = cnt_q;
        if (sync2_q == button_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            button_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign button_o = button_q;
    assign stable_o = (sync2_q == button_q);

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - per-button debounce array; BUTTON_ACTIVE_LOW_EN selects active-low pins
module button_debounce
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS     = NUM_BUTTONS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic [NUM_BUTTONS-1:0] KEY_IN,
    output logic [NUM_BUTTONS-1:0] BUTTONS,
    output logic [NUM_BUTTONS-1:0] STABLE
);

    logic [NUM_BUTTONS-1:0] key_pressed;

`ifdef BUTTON_ACTIVE_LOW_EN
    // Board keys pull low when pressed; an idle-high pin reads as released.
    assign key_pressed = ~KEY_IN;
`else
    assign key_pressed = KEY_IN;
`endif

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk_i    (CLOCK),
            .resetn_i (RESET),
            .key_i    (key_pressed[i]),
            .button_o (BUTTONS[i]),
            .stable_o (STABLE[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed bench for button_debounce with DEBOUNCE_CYCLES=4
module tb_button_debounce;

`ifdef BUTTON_ACTIVE_LOW_EN
    localparam logic [3:0] PIN_INV = 4'hF;
`else
    localparam logic [3:0] PIN_INV = 4'h0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] key_in;
    logic [3:0] buttons;
    logic [3:0] stable;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_debounce #(
        .NUM_BUTTONS     (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLOCK   (clk),
        .RESET   (resetn),
        .KEY_IN  (key_in),
        .BUTTONS (buttons),
        .STABLE  (stable)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the logical (pressed = 1) level, mapped onto the pin polarity of this build.
    task automatic set_key(input logic [3:0] v);
        key_in = v ^ PIN_INV;
    endtask

    task automatic settle(input string tag, input logic [3:0] v);
        set_key(v);
        repeat (8) tick();
        check(tag, {28'd0, buttons}, {28'd0, v});
    endtask

    logic       seen;
    int         trans;
    logic       prev;

    initial begin
        resetn = 1'b0;
        set_key(4'b1111);

        // Reset with all keys pressed
        repeat (2) tick();
        check("rst_buttons", {28'd0, buttons}, 32'h0);
        check("rst_stable", {28'd0, stable}, 32'hF);
        resetn = 1'b1;
        repeat (2) tick();
        check("rst_stable_pending", {28'd0, stable}, 32'h0);
        repeat (3) tick();
        check("rst_edge5_low", {28'd0, buttons}, 32'h0);
        tick();
        check("rst_edge6_high", {28'd0, buttons}, 32'hF);
        check("rst_stable_done", {28'd0, stable}, 32'hF);

        // Clean press on bit 0
        settle("clean_pre", 4'b0000);
        set_key(4'b0001);
        tick();
        check("clean_n_stable", {28'd0, stable}, 32'hF);
        tick();
        check("clean_n1_stable", {31'd0, stable[0]}, 32'd0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check("clean_wait_stable", {31'd0, stable[0]}, 32'd0);
            check("clean_wait_buttons", {28'd0, buttons}, 32'h0);
        end
        tick();
        check("clean_rise", {28'd0, buttons}, 32'h1);
        check("clean_rise_stable", {28'd0, stable}, 32'hF);
        repeat (5) tick();
        check("clean_hold", {28'd0, buttons}, 32'h1);

        // Bounce on bit 1
        settle("bounce_pre", 4'b0000);
        seen  = 1'b0;
        trans = 0;
        prev  = buttons[1];
        for (int k = 0; k < 4; k++) begin
            set_key((k % 2 == 0) ? 4'b0010 : 4'b0000);
            tick();
            seen = seen | buttons[1];
            if (buttons[1] != prev) trans++;
            prev = buttons[1];
        end
        set_key(4'b0010);
        for (int k = 1; k <= 5; k++) begin
            tick();
            seen = seen | buttons[1];
            if (buttons[1] != prev) trans++;
            prev = buttons[1];
        end
        check("bounce_no_early", {31'd0, seen}, 32'd0);
        tick();
        check("bounce_rise", {28'd0, buttons}, 32'h2);
        if (buttons[1] != prev) trans++;
        prev = buttons[1];
        repeat (6) begin
            tick();
            if (buttons[1] != prev) trans++;
            prev = buttons[1];
        end
        check("bounce_one_transition", trans, 32'd1);

        // Simultaneous multi-channel change
        settle("simul_pre", 4'b0000);
        seen = 1'b0;
        set_key(4'b1010);
        repeat (2) begin
            tick();
            if (buttons == 4'b1010) seen = 1'b1;
        end
        set_key(4'b0101);
        repeat (5) begin
            tick();
            if (buttons == 4'b1010) seen = 1'b1;
        end
        check("simul_edge5", {28'd0, buttons}, 32'h0);
        tick();
        check("simul_edge6", {28'd0, buttons}, 32'h5);
        repeat (6) begin
            tick();
            if (buttons == 4'b1010) seen = 1'b1;
        end
        check("simul_never_1010", {31'd0, seen}, 32'd0);
        check("simul_final", {28'd0, buttons}, 32'h5);

        // Reset in the middle of a count
        settle("midrst_pre", 4'b0000);
        set_key(4'b0100);
        repeat (3) tick();
        check("midrst_before", {28'd0, buttons}, 32'h0);
        resetn = 1'b0;
        tick();
        check("midrst_in_buttons", {28'd0, buttons}, 32'h0);
        check("midrst_in_stable", {28'd0, stable}, 32'hF);
        resetn = 1'b1;
        repeat (5) tick();
        check("midrst_edge5", {28'd0, buttons}, 32'h0);
        tick();
        check("midrst_edge6", {28'd0, buttons}, 32'h4);

`ifdef BUTTON_ACTIVE_LOW_EN
        // Raw pin levels: idle high is released, low is pressed
        key_in = 4'b1111;
        repeat (8) tick();
        check("al_idle", {28'd0, buttons}, 32'h0);
        key_in = 4'b1110;
        repeat (5) tick();
        check("al_edge5", {28'd0, buttons}, 32'h0);
        tick();
        check("al_edge6", {28'd0, buttons}, 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
